// File: rtl/hazard_stall_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: D-stage operand hazards against E/M results,
// HI/LO mult/div busy tracking, and a saturating stall-cycle counter.
`timescale 1ns/1ps
module hazard_stall_ctrl #(
    parameter int unsigned MULT_LAT = 5,
    parameter int unsigned DIV_LAT  = 10,
    parameter int unsigned CNT_W    = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  d_rs,
    input  logic [4:0]  d_rt,
    input  logic [1:0]  d_tuse_rs,
    input  logic [1:0]  d_tuse_rt,
    input  logic        d_is_md,
    input  logic [4:0]  e_wa,
    input  logic [4:0]  m_wa,
    input  logic [1:0]  e_tnew,
    input  logic [1:0]  m_tnew,
    input  logic        e_md_start,
    input  logic        e_md_div,
    output logic        freeze_pc,
    output logic        freeze_d,
    output logic        flush_e,
    output logic [1:0]  stall_cause,
    output logic        md_busy,
    output logic [15:0] stall_cnt
);

    localparam int unsigned CNT_STALL_W = 16;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_t;

    md_state_t              r_state;
    md_state_t              w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic [CNT_STALL_W-1:0] r_stall_cnt;
    logic                   w_md_busy;
    logic                   w_hz_rs;
    logic                   w_hz_rt;
    logic                   w_hz;
    logic                   w_ms;
    logic                   w_stall;

    // A source stalls when a producer ahead of it finishes later than the operand is needed.
    always_comb begin
        w_hz_rs = (d_rs != 5'd0) && (d_tuse_rs != 2'd3) &&
                  (((d_rs == e_wa) && (d_tuse_rs < e_tnew)) ||
                   ((d_rs == m_wa) && (d_tuse_rs < m_tnew)));
        w_hz_rt = (d_rt != 5'd0) && (d_tuse_rt != 2'd3) &&
                  (((d_rt == e_wa) && (d_tuse_rt < e_tnew)) ||
                   ((d_rt == m_wa) && (d_tuse_rt < m_tnew)));
        w_hz    = w_hz_rs | w_hz_rt;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // A start seen while already busy is ignored: no reload, the countdown carries on.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        unique case (r_state)
            ST_IDLE: begin
                if (e_md_start) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
                end
            end
            ST_BUSY: begin
                w_cnt_nxt = r_cnt - CNT_W'(1);
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        w_md_busy = 1'b0;
        if (e_md_start || (r_state == ST_BUSY)) begin
            w_md_busy = 1'b1;
        end
    end

    assign w_ms    = d_is_md & w_md_busy;
    assign w_stall = w_hz | w_ms;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cnt <= '0;
        end else if (w_stall && (r_stall_cnt != {CNT_STALL_W{1'b1}})) begin
            r_stall_cnt <= r_stall_cnt + CNT_STALL_W'(1);
        end
    end

    // Combinational outputs are masked so nothing leaks out while reset is held.
    assign freeze_pc   = reset & w_stall;
    assign freeze_d    = reset & w_stall;
    assign flush_e     = reset & w_stall;
    assign stall_cause = {reset & w_ms, reset & w_hz};
    assign md_busy     = reset & w_md_busy;
    assign stall_cnt   = r_stall_cnt;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl.
`timescale 1ns/1ps
module tb_hazard_stall_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  d_rs;
    logic [4:0]  d_rt;
    logic [1:0]  d_tuse_rs;
    logic [1:0]  d_tuse_rt;
    logic        d_is_md;
    logic [4:0]  e_wa;
    logic [4:0]  m_wa;
    logic [1:0]  e_tnew;
    logic [1:0]  m_tnew;
    logic        e_md_start;
    logic        e_md_div;
    logic        freeze_pc;
    logic        freeze_d;
    logic        flush_e;
    logic [1:0]  stall_cause;
    logic        md_busy;
    logic [15:0] stall_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    hazard_stall_ctrl u_dut (
        .clk         (clk),
        .reset       (reset),
        .d_rs        (d_rs),
        .d_rt        (d_rt),
        .d_tuse_rs   (d_tuse_rs),
        .d_tuse_rt   (d_tuse_rt),
        .d_is_md     (d_is_md),
        .e_wa        (e_wa),
        .m_wa        (m_wa),
        .e_tnew      (e_tnew),
        .m_tnew      (m_tnew),
        .e_md_start  (e_md_start),
        .e_md_div    (e_md_div),
        .freeze_pc   (freeze_pc),
        .freeze_d    (freeze_d),
        .flush_e     (flush_e),
        .stall_cause (stall_cause),
        .md_busy     (md_busy),
        .stall_cnt   (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    task automatic check_stall(input string tag, input logic exp_stall, input logic [1:0] exp_cause);
        check_val({tag, "_fpc"},   32'(freeze_pc),   32'(exp_stall));
        check_val({tag, "_fd"},    32'(freeze_d),    32'(exp_stall));
        check_val({tag, "_fe"},    32'(flush_e),     32'(exp_stall));
        check_val({tag, "_cause"}, 32'(stall_cause), 32'(exp_cause));
    endtask

    task automatic clr_inputs();
        d_rs = 5'd0; d_rt = 5'd0; d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 1'b0;
        e_wa = 5'd0; m_wa = 5'd0; e_tnew = 2'd0; m_tnew = 2'd0;
        e_md_start = 1'b0; e_md_div = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        clr_inputs();
        reset = 1'b0;
        // Hazard inputs asserted during reset must not reach the outputs.
        d_rs = 5'd8; d_tuse_rs = 2'd0; e_wa = 5'd8; e_tnew = 2'd2; d_is_md = 1'b1; e_md_start = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_stall("rst", 1'b0, 2'b00);
        check_val("rst_busy", 32'(md_busy), 32'd0);
        check_val("rst_cnt", 32'(stall_cnt), 32'd0);
        clr_inputs();
        reset = 1'b1;
        step();

        // lw $8 in E, add reading $8 in D
        d_rs = 5'd8; d_tuse_rs = 2'd1; e_wa = 5'd8; e_tnew = 2'd2;
        #1;
        check_stall("lw_e", 1'b1, 2'b01);
        check_val("lw_e_busy", 32'(md_busy), 32'd0);
        step();
        e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd8; m_tnew = 2'd1;
        #1;
        check_stall("lw_m", 1'b0, 2'b00);
        check_val("lw_m_cnt", 32'(stall_cnt), 32'd1);
        // rt needed now, M result not ready yet
        d_rs = 5'd0; d_tuse_rs = 2'd3; d_rt = 5'd8; d_tuse_rt = 2'd0;
        #1;
        check_stall("rt_m", 1'b1, 2'b01);
        step();
        check_val("rt_m_cnt", 32'(stall_cnt), 32'd2);

        clr_inputs();
        d_rs = 5'd0; e_wa = 5'd0; e_tnew = 2'd2; d_tuse_rs = 2'd0;
        #1;
        check_stall("r0", 1'b0, 2'b00);
        d_rs = 5'd5; e_wa = 5'd5; d_tuse_rs = 2'd3;
        #1;
        check_stall("tuse3", 1'b0, 2'b00);
        step();
        check_val("tuse3_cnt", 32'(stall_cnt), 32'd2);

        // mult start with mflo waiting in D
        clr_inputs();
        e_md_start = 1'b1; d_is_md = 1'b1;
        #1;
        check_val("mul_c0_busy", 32'(md_busy), 32'd1);
        check_stall("mul_c0", 1'b1, 2'b10);
        step();
        e_md_start = 1'b0;
        for (int c = 1; c <= 5; c++) begin
            #1;
            check_val($sformatf("mul_c%0d_busy", c), 32'(md_busy), 32'd1);
            check_val($sformatf("mul_c%0d_fd", c), 32'(freeze_d), 32'd1);
            step();
        end
        check_val("mul_c6_busy", 32'(md_busy), 32'd0);
        check_val("mul_c6_fd", 32'(freeze_d), 32'd0);
        check_val("mul_cnt", 32'(stall_cnt), 32'd8);

        // div, second start at cycle 3 must not reload
        clr_inputs();
        for (int c = 0; c <= 11; c++) begin
            e_md_start = (c == 0 || c == 3);
            e_md_div   = (c == 0);
            #1;
            check_val($sformatf("div_c%0d_busy", c), 32'(md_busy), (c <= 10) ? 32'd1 : 32'd0);
            step();
        end
        check_val("div_cnt", 32'(stall_cnt), 32'd8);

        // async reset in the middle of a div busy period
        clr_inputs();
        e_md_start = 1'b1; e_md_div = 1'b1; d_is_md = 1'b1;
        step();
        e_md_start = 1'b0; e_md_div = 1'b0;
        repeat (3) step();
        #1;
        check_val("rdiv_c4_busy", 32'(md_busy), 32'd1);
        check_stall("rdiv_c4", 1'b1, 2'b10);
        #2;
        reset = 1'b0;
        #1;
        check_stall("rdiv_rst", 1'b0, 2'b00);
        check_val("rdiv_rst_busy", 32'(md_busy), 32'd0);
        check_val("rdiv_rst_cnt", 32'(stall_cnt), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("rdiv_rel_busy", 32'(md_busy), 32'd0);
        check_stall("rdiv_rel", 1'b0, 2'b00);
        step();
        check_val("rdiv_rel2_busy", 32'(md_busy), 32'd0);
        check_val("rdiv_rel2_cnt", 32'(stall_cnt), 32'd0);

        // hazard plus md busy together, then saturate the counter
        clr_inputs();
        d_rs = 5'd9; d_tuse_rs = 2'd0; e_wa = 5'd9; e_tnew = 2'd1;
        d_is_md = 1'b1; e_md_start = 1'b1;
        #1;
        check_stall("both", 1'b1, 2'b11);
        step();
        check_val("both_cnt1", 32'(stall_cnt), 32'd1);
        check_val("both_cause", 32'(stall_cause), 32'd3);
        repeat (65533) @(posedge clk);
        #1;
        check_val("sat_fffe", 32'(stall_cnt), 32'hFFFE);
        repeat (6) @(posedge clk);
        #1;
        check_val("sat_ffff", 32'(stall_cnt), 32'hFFFF);
        check_stall("sat", 1'b1, 2'b11);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
